// File: rtl/prog_ram_arbiter_pkg.sv
// Shared types and constants for the program RAM arbiter.
// Covers the state encoding, the reset-vector addresses and the reset counter width.
package prog_ram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VEC_LO = 3'd2,
    ST_VEC_HI = 3'd3,
    ST_RST    = 3'd4
  } arb_state_e;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] VEC_ADDR_LO   = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_ADDR_HI   = 16'hFFFD;
  localparam logic [ADDR_W-1:0] VEC_PROT_BASE = 16'hFFFA;
  localparam logic [ADDR_W-1:0] COUNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/prog_ram_arbiter_if.sv
// Loader, CPU and RAM-side signals of the program RAM arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface prog_ram_arbiter_if;
  import prog_ram_arbiter_pkg::*;

  logic              ask_for_ram;
  logic              end_of_data;
  logic [ADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_write_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              cpu_rdy;
  logic              cpu_reset;
  logic [ADDR_W-1:0] load_count;
  logic              vec_err;

  modport master (
    input  ask_for_ram, end_of_data, ld_waddr, ld_wdata, ld_write_en,
    input  cpu_addr, cpu_dout, cpu_we,
    output ram_addr, ram_wdata, ram_we, cpu_rdy, cpu_reset, load_count, vec_err
  );

  modport slave (
    output ask_for_ram, end_of_data, ld_waddr, ld_wdata, ld_write_en,
    output cpu_addr, cpu_dout, cpu_we,
    input  ram_addr, ram_wdata, ram_we, cpu_rdy, cpu_reset, load_count, vec_err
  );
endinterface

// File: rtl/prog_reset_pulse.sv
// Loadable down-counter timing a reset pulse; done_c flags the final counted cycle.
// Counting only advances while tick is high, so the count can be armed ahead of use.
module prog_reset_pulse
  import prog_ram_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= load_val;
    else       cnt_q <= cnt_d;
  end

  assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/prog_ram_arbiter.sv
// Arbitrates the program RAM between the 6502 core and the UART loader, then rewrites
// the reset vector to LOAD_BASE and pulses the CPU reset so a freshly loaded program boots.
module prog_ram_arbiter
  import prog_ram_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE    = 16'h0600,
  parameter int unsigned       RESET_CYCLES = 8
) (
  input  logic                 clk_ram,
  input  logic                 reset,
  prog_ram_arbiter_if.master   bus
);

  arb_state_e        state_q, state_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [ADDR_W-1:0] load_count_q, load_count_d;
  logic              vec_err_q, vec_err_d;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ld_take;
  logic              ld_prot;
  logic              pulse_start;
  logic              pulse_tick;
  logic              pulse_done;

  prog_reset_pulse u_pulse (
    .clk      (clk_ram),
    .reset    (reset),
    .start    (pulse_start),
    .tick     (pulse_tick),
    .load_val (CNT_W'(RESET_CYCLES)),
    .done_c   (pulse_done)
  );

  // Next state, port mux and session bookkeeping.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    vec_err_d    = vec_err_q;
    ram_addr     = bus.cpu_addr;
    ram_wdata    = bus.cpu_dout;
    ram_we       = 1'b0;
    ld_take      = 1'b0;
    pulse_start  = 1'b0;
    pulse_tick   = 1'b0;
    ld_prot      = (bus.ld_waddr >= VEC_PROT_BASE);

    unique case (state_q)
      ST_RUN: begin
        if (bus.ask_for_ram) begin
          // Loader owns the mux from the request cycle, but is not granted a write yet.
          state_d      = ST_LOAD;
          load_count_d = '0;
          ram_addr     = bus.ld_waddr;
          ram_wdata    = bus.ld_wdata;
        end else begin
          ram_we = bus.cpu_we;
        end
      end
      ST_LOAD: begin
        ld_take = 1'b1;
        if (bus.end_of_data)       state_d = ST_VEC_LO;
        else if (!bus.ask_for_ram) state_d = ST_RUN;
      end
      ST_VEC_LO: begin
        if (bus.ld_write_en) begin
          ld_take = 1'b1;
        end else begin
          ram_addr  = VEC_ADDR_LO;
          ram_wdata = LOAD_BASE[7:0];
          ram_we    = 1'b1;
          state_d   = ST_VEC_HI;
        end
      end
      ST_VEC_HI: begin
        if (bus.ld_write_en) begin
          ld_take = 1'b1;
        end else begin
          ram_addr    = VEC_ADDR_HI;
          ram_wdata   = LOAD_BASE[15:8];
          ram_we      = 1'b1;
          pulse_start = 1'b1;
          state_d     = ST_RST;
        end
      end
      ST_RST: begin
        pulse_tick = 1'b1;
        if (pulse_done) state_d = ST_RUN;
      end
      default: state_d = ST_VEC_LO;
    endcase

    // Loader writes into the vector area are dropped but still counted.
    if (ld_take) begin
      ram_addr  = bus.ld_waddr;
      ram_wdata = bus.ld_wdata;
      ram_we    = bus.ld_write_en && !ld_prot;
      if (bus.ld_write_en) begin
        if (load_count_q != COUNT_MAX) load_count_d = load_count_q + ADDR_W'(1);
        if (ld_prot)                   vec_err_d    = 1'b1;
      end
    end

    cpu_rdy_d   = (state_d == ST_RUN) || (state_d == ST_RST);
    cpu_reset_d = (state_d == ST_RST) ||
                  (cpu_reset_q && ((state_d == ST_VEC_LO) || (state_d == ST_VEC_HI)));
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q      <= ST_VEC_LO;
      cpu_rdy_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_count_q <= '0;
      vec_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rdy_q    <= cpu_rdy_d;
      cpu_reset_q  <= cpu_reset_d;
      load_count_q <= load_count_d;
      vec_err_q    <= vec_err_d;
    end
  end

  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.ram_we     = ram_we;
  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.load_count = load_count_q;
  assign bus.vec_err    = vec_err_q;

endmodule
